// File: rtl/ecc_point_seq_pkg.sv
// ecc_point_seq_pkg: GF opcodes, regfile indices, FSM states and micro-op format for the point sequencer.
package ecc_point_seq_pkg;
  typedef enum logic [1:0] {GF_ADD, GF_SUB, GF_MUL, GF_DIV} gf_op_e;
  typedef enum logic [3:0] {R_X1, R_Y1, R_X2, R_Y2, R_A, R_T0, R_T1, R_L, R_X3, R_Y3} reg_e;
  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_ISSUE, S_WAIT, S_DONE} state_e;
  localparam int NREG = 10;
  typedef struct packed {
    logic   last;
    gf_op_e op;
    reg_e   dst;
    reg_e   src1;
    reg_e   src0;
  } uop_t;
  localparam int UOP_W = $bits(uop_t);
  function automatic uop_t mk(gf_op_e op, reg_e dst, reg_e s0, reg_e s1, logic last = 1'b0);
    return '{last, op, dst, s1, s0};
  endfunction
endpackage

// File: rtl/ecc_point_seq_uop_rom.sv
// ecc_point_seq_uop_rom: micro-op programs; point add at 0-8, point double at 16-27.
module ecc_point_seq_uop_rom
  import ecc_point_seq_pkg::*;
(
  input  logic             dbl,
  input  logic [3:0]       pc,
  output logic [UOP_W-1:0] uop
);
  always_comb begin
    case ({dbl, pc})
      5'd0:    uop = mk(GF_SUB, R_T0, R_Y2, R_Y1);
      5'd1:    uop = mk(GF_SUB, R_T1, R_X2, R_X1);
      5'd2:    uop = mk(GF_DIV, R_L,  R_T0, R_T1);
      5'd3:    uop = mk(GF_MUL, R_T0, R_L,  R_L);
      5'd4:    uop = mk(GF_SUB, R_T0, R_T0, R_X1);
      5'd5:    uop = mk(GF_SUB, R_X3, R_T0, R_X2);
      5'd6:    uop = mk(GF_SUB, R_T0, R_X1, R_X3);
      5'd7:    uop = mk(GF_MUL, R_T0, R_L,  R_T0);
      5'd8:    uop = mk(GF_SUB, R_Y3, R_T0, R_Y1, 1'b1);
      5'd16:   uop = mk(GF_MUL, R_T0, R_X1, R_X1);
      5'd17:   uop = mk(GF_ADD, R_T1, R_T0, R_T0);
      5'd18:   uop = mk(GF_ADD, R_T0, R_T1, R_T0);
      5'd19:   uop = mk(GF_ADD, R_T0, R_T0, R_A);
      5'd20:   uop = mk(GF_ADD, R_T1, R_Y1, R_Y1);
      5'd21:   uop = mk(GF_DIV, R_L,  R_T0, R_T1);
      5'd22:   uop = mk(GF_MUL, R_T0, R_L,  R_L);
      5'd23:   uop = mk(GF_SUB, R_T0, R_T0, R_X1);
      5'd24:   uop = mk(GF_SUB, R_X3, R_T0, R_X1);
      5'd25:   uop = mk(GF_SUB, R_T0, R_X1, R_X3);
      5'd26:   uop = mk(GF_MUL, R_T0, R_L,  R_T0);
      5'd27:   uop = mk(GF_SUB, R_Y3, R_T0, R_Y1, 1'b1);
      default: uop = '0;
    endcase
  end
endmodule

// File: rtl/ecc_point_seq.sv
// ecc_point_seq: affine EC point add/double sequencer driving an external GF(p) arithmetic unit.
module ecc_point_seq
  import ecc_point_seq_pkg::*;
#(
  parameter int SIZE    = 32,
  parameter int TIMEOUT = 1024
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic            i_mode,
  input  logic [SIZE-1:0] i_x1,
  input  logic [SIZE-1:0] i_y1,
  input  logic [SIZE-1:0] i_x2,
  input  logic [SIZE-1:0] i_y2,
  input  logic [SIZE-1:0] i_a,
  input  logic [SIZE-1:0] i_prime,
  output logic [SIZE-1:0] o_gf_in0,
  output logic [SIZE-1:0] o_gf_in1,
  output logic [1:0]      o_gf_op,
  output logic            o_gf_go,
  input  logic [SIZE-1:0] i_gf_result,
  input  logic            i_gf_done,
  output logic [SIZE-1:0] o_x3,
  output logic [SIZE-1:0] o_y3,
  output logic            o_inf,
  output logic            o_err,
  output logic            o_busy,
  output logic            o_done
);
  localparam int WDW = $clog2(TIMEOUT + 1);
  state_e          state, next;
  logic [SIZE-1:0] rf [NREG];
  logic [3:0]      pc;
  logic            dbl, mode;
  logic [WDW-1:0]  wd;
  uop_t            uop;
  logic            timeout, inf_case;
  ecc_point_seq_uop_rom rom (.dbl(dbl), .pc(pc), .uop(uop));
  // Watchdog counts from the go cycle, so DONE lands exactly TIMEOUT cycles after go.
  assign timeout  = wd == WDW'(TIMEOUT - 1);
  assign inf_case = mode ? rf[R_Y1] == '0 : (rf[R_X1] == rf[R_X2] && rf[R_Y1] != rf[R_Y2]);
  assign o_x3     = rf[R_X3];
  assign o_y3     = rf[R_Y3];
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_IDLE;
    else       state <= next;
  end
  always_comb begin
    next = state;
    case (state)
      S_IDLE:  next = i_start ? S_CHECK : S_IDLE;
      S_CHECK: next = inf_case ? S_DONE : S_ISSUE;
      S_ISSUE: next = S_WAIT;
      S_WAIT:  next = i_gf_done ? (uop.last ? S_DONE : S_ISSUE) : (timeout ? S_DONE : S_WAIT);
      default: next = S_IDLE;
    endcase
  end
  always_comb begin
    o_gf_go  = state == S_ISSUE;
    o_busy   = state != S_IDLE;
    o_done   = state == S_DONE;
    o_gf_in0 = rf[uop.src0];
    o_gf_in1 = rf[uop.src1];
    o_gf_op  = uop.op;
  end
  // Modulus is consumed by the GF unit directly; the sequencer never does modular math.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      pc    <= '0;
      dbl   <= 1'b0;
      mode  <= 1'b0;
      wd    <= '0;
      o_inf <= 1'b0;
      o_err <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (i_start) begin
          rf[R_X1] <= i_x1;
          rf[R_Y1] <= i_y1;
          rf[R_X2] <= i_x2;
          rf[R_Y2] <= i_y2;
          rf[R_A]  <= i_a;
          rf[R_T0] <= '0;
          rf[R_T1] <= '0;
          rf[R_L]  <= '0;
          rf[R_X3] <= '0;
          rf[R_Y3] <= '0;
          mode     <= i_mode;
          pc       <= '0;
          wd       <= '0;
          o_inf    <= 1'b0;
          o_err    <= 1'b0;
        end
        S_CHECK: begin
          dbl   <= mode | rf[R_X1] == rf[R_X2];
          o_inf <= inf_case;
          pc    <= '0;
        end
        S_ISSUE: wd <= wd + WDW'(1);
        S_WAIT: if (i_gf_done) begin
          rf[uop.dst] <= i_gf_result;
          pc          <= pc + 4'd1;
          wd          <= '0;
        end else if (timeout) begin
          o_err <= 1'b1;
          wd    <= '0;
        end else wd <= wd + WDW'(1);
        default: ;
      endcase
    end
  end
  logic unused_prime;
  assign unused_prime = ^i_prime;
endmodule
